// File: rtl/ser_pkg.sv
// Shared types and constants for the serial word transmitter.
package ser_pkg;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    localparam logic BIT_MSB_FIRST = 1'b1;
    localparam logic BIT_LSB_FIRST = 1'b0;

endpackage

// File: rtl/ser_word_tx_if.sv
// Word-in / bit-out bundle for ser_word_tx; slave is the transmitter's view.
interface ser_word_tx_if #(parameter int W = 8);
    import ser_pkg::*;

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         shift_en;
    logic         ser_out;
    logic         ser_valid;
    logic         word_done;
    logic         busy;

    modport master (
        output in_valid, in_data, shift_en,
        input  in_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  in_valid, in_data, shift_en,
        output in_ready, ser_out, ser_valid, word_done, busy
    );

endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding register that lets the next word wait while the shifter is busy.
module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full
);

    logic [W-1:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (wr) begin
                data <= wdata;
                full <= 1'b1;
            end else if (rd) begin
                full <= 1'b0;
            end
        end
    end

    assign rdata = data;

    // The upstream ready is !full, so a write can never coincide with a drain of a full entry.
    a_no_rd_wr_full: assert property (@(posedge clk) disable iff (rst) !(rd && wr && full));

endmodule

// File: rtl/ser_word_tx.sv
// Parallel-to-serial transmitter: one bit per shift strobe, gapless word streaming.
module ser_word_tx
    import ser_pkg::*;
#(
    parameter int   W          = 8,
    parameter logic MSB_FIRST  = BIT_MSB_FIRST,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    ser_word_tx_if.slave  bus
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    tx_state_t    state;
    logic [W-1:0] shift_reg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] bit_idx;

    logic         pend_valid;
    logic [W-1:0] pend_data;
    logic         accept;
    logic         last_bit;
    logic         hold_wr;
    logic         hold_rd;

    assign last_bit = (state == TX_SHIFT) && bus.shift_en && (cnt == CW'(W - 1));
    assign accept   = bus.in_valid && !pend_valid;
    // Last-bit accepts bypass the buffer straight into the shifter.
    assign hold_wr  = accept && (state == TX_SHIFT) && !last_bit;
    assign hold_rd  = last_bit && pend_valid;

    ser_hold_buf #(.W(W)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .wr    (hold_wr),
        .wdata (bus.in_data),
        .rd    (hold_rd),
        .rdata (pend_data),
        .full  (pend_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TX_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (accept) begin
                        shift_reg <= bus.in_data;
                        cnt       <= '0;
                        state     <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (bus.shift_en) begin
                        if (!last_bit) begin
                            cnt <= cnt + 1'b1;
                        end else if (pend_valid) begin
                            shift_reg <= pend_data;
                            cnt       <= '0;
                        end else if (bus.in_valid) begin
                            shift_reg <= bus.in_data;
                            cnt       <= '0;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign bit_idx       = (MSB_FIRST == BIT_MSB_FIRST) ? (CW'(W - 1) - cnt) : cnt;
    assign bus.ser_out   = (state == TX_SHIFT) ? shift_reg[bit_idx] : IDLE_LEVEL;
    assign bus.ser_valid = (state == TX_SHIFT);
    assign bus.word_done = last_bit;
    assign bus.in_ready  = !pend_valid;
    assign bus.busy      = (state == TX_SHIFT) || pend_valid;

endmodule

// File: doc/ser_word_tx.md
Name: ser_word_tx

Overview:
- Parallel-to-serial transmitter directly upstream of the serial "101" sequence detector.
- Accepts W-bit words over a valid/ready handshake and drives one bit per shift strobe onto the detector's serial data input.
- A one-entry holding buffer allows back-to-back words to stream with no idle bit between them.

Parameters:
- W, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 1'b0: level driven on ser_out when no word is being sent.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  W  upstream word.
- in_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  bit strobe; tie to 1 for one bit per clk, which is the rate the detector expects.
- ser_out  out  1  serial bit, connects to the detector's d input.
- ser_valid  out  1  ser_out carries a payload bit.
- word_done  out  1  one-cycle pulse when the last bit of a word is consumed.
- busy  out  1  a word is in the shifter or the holding buffer.

Behaviour:
- Reset (asynchronous): state=IDLE, shift_reg=0, cnt=0, pend_valid=0.
  - Outputs during reset: ser_out=IDLE_LEVEL, ser_valid=0, in_ready=1, word_done=0, busy=0.
- States (shared enum):
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word; cnt (width $clog2(W)) indexes the current bit.
- in_ready = !pend_valid. Accept occurs when in_valid && in_ready at a rising edge.
- Invariant: pend_valid=0 whenever state=IDLE.
- IDLE, accept at edge k: shift_reg<=in_data, cnt<=0, state<=SHIFT. The first bit appears on ser_out during cycle k+1, giving one cycle of latency.
- SHIFT, accept: the word is written to the holding buffer (pend_data<=in_data, pend_valid<=1).
- SHIFT, output bit:
  - ser_out = shift_reg[W-1-cnt] when MSB_FIRST=1, shift_reg[cnt] otherwise.
  - ser_valid=1.
- SHIFT, shift_en=1 and cnt<W-1: cnt<=cnt+1.
- SHIFT, shift_en=0: all state holds and ser_out repeats the same bit.
- SHIFT, last bit (shift_en=1 and cnt==W-1): word_done=1 combinationally in that cycle, then the first matching case below applies:
  - pend_valid=1: shift_reg<=pend_data, pend_valid<=0, cnt<=0, stay SHIFT (gapless).
  - pend_valid=0 and in_valid=1: the word is accepted (in_ready=1) and loads directly into the shifter, cnt<=0, stay SHIFT (gapless bypass).
  - Otherwise: state<=IDLE.
- Simultaneous accept into the holding buffer and last-bit reload: this cannot occur, because in_ready=0 whenever pend_valid=1.
- ser_out=IDLE_LEVEL and ser_valid=0 whenever state=IDLE.
- busy = (state==SHIFT) || pend_valid.
- rst asserted mid-word: the current word and any pending word are discarded with no word_done. The block returns to reset values immediately and resumes normally after deassertion.
- in_data is sampled only on accept; later changes to in_data do not affect a captured word.

Decomposition:
- Package ser_pkg holds:
  - typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  - localparam BIT_MSB_FIRST=1'b1 and BIT_LSB_FIRST=1'b0.
- Sub-module ser_hold_buf (parameter W): the one-entry holding register.
  - Ports: wr, wdata, rd, rdata, full.
  - rd and wr must never be asserted in the same cycle while full; an SVA in ser_hold_buf checks this.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> ser_out=0, ser_valid=0, in_ready=1, busy=0, and no accept occurs.
- Single word: W=8, MSB_FIRST=1, shift_en=1, send 8'hA5 -> ser_out=1,0,1,0,0,1,0,1 over 8 cycles with ser_valid=1; word_done high in the 8th bit cycle; the downstream detector pulses out twice.
- Back-to-back: 8'hFF then 8'h00 with in_valid held -> 16 contiguous ser_valid cycles with no gap; in_ready low from the second accept until the first word's last-bit edge; word_done pulses in bit cycles 8 and 16.
- Strobe: shift_en pattern 1,0,0 repeating, word 8'h81 -> each bit held on ser_out for 3 cycles (24 cycles total); cnt advances only on strobes.
- Reset mid-word: 8'hF0 in flight at cnt=4 with 8'h0F pending, assert rst -> immediately ser_out=0, ser_valid=0, busy=0, in_ready=1; no word_done; the pending word is never transmitted.
- LSB order: MSB_FIRST=0, send 8'h01 -> ser_out=1 followed by seven 0 bits, then IDLE_LEVEL.
